rotate_kick_ctrl: RTL and testbench

ROTATE_KICK_CTRL -- requirements
Module: rotate_kick_ctrl

---
 rtl/rotate_kick_ctrl_if.sv | 31 +++
 rtl/rotate_kick_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rotate_kick_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotate_kick_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_kick_ctrl_if
//  Description : Candidate-pose handshake between the rotation/kick controller
//                and the playfield collision checker.
//                  chk_req     - one-cycle request, candidate pose is valid
//                  chk_x/y/rot - candidate pose, held for the whole test
//                  chk_done    - checker answer strobe
//                  chk_collide - checker verdict, meaningful with chk_done
//                master = controller side, slave = checker side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rotate_kick_ctrl_if;
  logic              chk_req;
  logic signed [4:0] chk_x;
  logic signed [5:0] chk_y;
  logic [1:0]        chk_rot;
  logic              chk_done;
  logic              chk_collide;

  modport master (
    output chk_req, chk_x, chk_y, chk_rot,
    input  chk_done, chk_collide
  );

  modport slave (
    input  chk_req, chk_x, chk_y, chk_rot,
    output chk_done, chk_collide
  );
endinterface
`default_nettype wire

// File: rtl/rotate_kick_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_kick_ctrl
//  Description : Tetromino rotation controller with wall-kick search. On a
//                rotate request the pose is captured and kick offsets are
//                tried in order against an external collision checker until
//                one fits (commit) or the table is exhausted (fail).
//  Ports       : clk, rst_n            - clock, synchronous active-low reset
//                rot_req, clockwise    - rotate request and direction
//                piece_type            - 0 = I piece (gets the extra kick)
//                cur_x/cur_y/cur_rot   - current pose, captured with rot_req
//                abort                 - drop an in-flight rotation
//                chk (master)          - collision checker handshake
//                busy, done, success   - status; done is a one-cycle pulse
//                new_x/new_y/new_rot   - last committed pose
//  Revision    : 1.0 - initial release
// ============================================================================
module rotate_kick_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rot_req,
  input  logic                  clockwise,
  input  logic [2:0]            piece_type,
  input  logic signed [4:0]     cur_x,
  input  logic signed [5:0]     cur_y,
  input  logic [1:0]            cur_rot,
  input  logic                  abort,
  rotate_kick_ctrl_if.master    chk,
  output logic                  busy,
  output logic                  done,
  output logic                  success,
  output logic signed [4:0]     new_x,
  output logic signed [5:0]     new_y,
  output logic [1:0]            new_rot
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [2:0]        k;
  logic [CNT_W-1:0]  cnt;
  logic              chk_req_q;
  logic              cap_cw;
  logic              cap_is_i;
  logic signed [4:0] cap_x;
  logic signed [5:0] cap_y;
  logic [1:0]        tgt_rot;

  logic signed [4:0] dx;
  logic signed [5:0] dy;
  logic signed [4:0] cand_x;
  logic signed [5:0] cand_y;
  logic              last_test;
  logic              resp_ok;
  logic              timeout;
  logic              collided;
  logic              accept;
  logic              advance;

  // Kick offset for the current test index.
  always_comb begin
    dx = '0;
    dy = '0;
    case (k)
      3'd1:    dx = -5'sd1;
      3'd2:    dx =  5'sd1;
      3'd3:    dy = -6'sd1;
      3'd4:    dx = cap_cw ? 5'sd2 : -5'sd2;
      default: ;
    endcase
  end

  // Candidate pose is derived from captured registers and k, so it stays
  // stable from ISSUE until WAIT resolves. Addition wraps at port width.
  assign cand_x = cap_x + dx;
  assign cand_y = cap_y + dy;

  assign chk.chk_req = chk_req_q;
  assign chk.chk_x   = cand_x;
  assign chk.chk_y   = cand_y;
  assign chk.chk_rot = tgt_rot;

  assign last_test = cap_is_i ? (k == 3'd4) : (k == 3'd3);

  // chk_req is registered out of ISSUE, so it is high in the first WAIT
  // cycle; an answer in that same cycle is not a response to this request.
  assign resp_ok  = chk.chk_done && !chk_req_q;
  // cnt counts WAIT cycles from 0; CNT_LAST marks the TIMEOUT-th cycle.
  assign timeout  = !resp_ok && (cnt == CNT_LAST);
  assign collided = (resp_ok && chk.chk_collide) || timeout;
  assign accept   = (state == ST_WAIT) && resp_ok && !chk.chk_collide && !abort;
  assign advance  = (state == ST_WAIT) && collided && !last_test && !abort;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (rot_req) state_nx = ST_ISSUE;
      ST_ISSUE:  state_nx = ST_WAIT;
      ST_WAIT: begin
        if (accept)        state_nx = ST_COMMIT;
        else if (collided) state_nx = last_test ? ST_FAIL : ST_ISSUE;
      end
      ST_COMMIT: state_nx = ST_IDLE;
      ST_FAIL:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    // abort wins over any checker answer in the same cycle
    if (abort && (state != ST_IDLE)) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      cnt       <= '0;
      chk_req_q <= 1'b0;
      cap_cw    <= 1'b0;
      cap_is_i  <= 1'b0;
      cap_x     <= '0;
      cap_y     <= '0;
      tgt_rot   <= '0;
      new_x     <= '0;
      new_y     <= '0;
      new_rot   <= '0;
    end else begin
      state     <= state_nx;
      chk_req_q <= (state == ST_ISSUE) && !abort;

      if ((state == ST_IDLE) && rot_req) begin
        cap_cw   <= clockwise;
        cap_is_i <= (piece_type == 3'd0);
        cap_x    <= cur_x;
        cap_y    <= cur_y;
        tgt_rot  <= cur_rot + (clockwise ? 2'd1 : 2'd3);
        k        <= '0;
      end else if (advance) begin
        k <= k + 3'd1;
      end

      if (state == ST_ISSUE)
        cnt <= '0;
      else if ((state == ST_WAIT) && (cnt != CNT_LAST))
        cnt <= cnt + CNT_W'(1);

      if (accept) begin
        new_x   <= cand_x;
        new_y   <= cand_y;
        new_rot <= tgt_rot;
      end
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_COMMIT) || (state == ST_FAIL);
  assign success = (state == ST_COMMIT);

endmodule
`default_nettype wire

// File: tb/tb_rotate_kick_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rotate_kick_ctrl
//  Description : Self-checking bench for rotate_kick_ctrl. Each rotation is
//                planned as a list of checker answers; expected outputs per
//                cycle come from a timeline computed from that plan.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rotate_kick_ctrl;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, rot_req, clockwise, abort;
  logic [2:0]        piece_type;
  logic signed [4:0] cur_x;
  logic signed [5:0] cur_y;
  logic [1:0]        cur_rot;
  logic              busy, done, success;
  logic signed [4:0] new_x;
  logic signed [5:0] new_y;
  logic [1:0]        new_rot;

  rotate_kick_ctrl_if chk_bus ();

  rotate_kick_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rot_req    (rot_req),
    .clockwise  (clockwise),
    .piece_type (piece_type),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .cur_rot    (cur_rot),
    .abort      (abort),
    .chk        (chk_bus.master),
    .busy       (busy),
    .done       (done),
    .success    (success),
    .new_x      (new_x),
    .new_y      (new_y),
    .new_rot    (new_rot)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // expectations for the current cycle, written by the stimulus
  bit cmp_en, op_first, pin_en;
  bit e_busy, e_done, e_succ, e_req, e_pose_v;
  int e_cx, e_cy, e_crot, e_nx, e_ny, e_nrot;
  int cyc;
  int pin_done_at, pin_req, pin_done, pin_succ, pin_nx, pin_ny, pin_nrot;

  // model state: last committed pose
  int m_nx, m_ny, m_nrot;

  // plan of one rotation
  bit                p_cw;
  logic [2:0]        p_type;
  logic signed [4:0] p_x;
  logic signed [5:0] p_y;
  logic [1:0]        p_rot;
  int                p_delay [5];   // 0 = checker silent, else answer delay after chk_req
  bit                p_coll  [5];
  bit                p_early [5];   // spurious no-collide answer alongside chk_req
  int                p_abort, p_rst;

  // per-rotation observations, owned by the compare process
  int req_cnt, done_cnt, succ_cnt, done_at;

  task automatic check(input string nm, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      if (op_first) begin
        req_cnt = 0; done_cnt = 0; succ_cnt = 0; done_at = -1;
      end
      check("busy",    busy,            e_busy);
      check("done",    done,            e_done);
      check("success", success,         e_succ);
      check("chk_req", chk_bus.chk_req, e_req);
      check("new_x",   new_x,           e_nx);
      check("new_y",   new_y,           e_ny);
      check("new_rot", new_rot,         e_nrot);
      if (e_pose_v) begin
        check("chk_x",   chk_bus.chk_x,   e_cx);
        check("chk_y",   chk_bus.chk_y,   e_cy);
        check("chk_rot", chk_bus.chk_rot, e_crot);
      end
      if (chk_bus.chk_req) req_cnt++;
      if (done) begin
        done_cnt++;
        done_at = cyc;
        if (success) succ_cnt++;
      end
      if (pin_en) begin
        check("pin_done_at", done_at,  pin_done_at);
        check("pin_req_cnt", req_cnt,  pin_req);
        check("pin_done_cnt", done_cnt, pin_done);
        check("pin_succ_cnt", succ_cnt, pin_succ);
        check("pin_new_x",   new_x,    pin_nx);
        check("pin_new_y",   new_y,    pin_ny);
        check("pin_new_rot", new_rot,  pin_nrot);
      end
    end
  end

  // Candidate pose of kick test k for the planned rotation.
  function automatic void pose(input int k, output int px, output int py, output int pr);
    int dx, dy;
    logic signed [4:0] tx;
    logic signed [5:0] ty;
    logic [1:0]        tr;
    dx = 0; dy = 0;
    case (k)
      1: dx = -1;
      2: dx = 1;
      3: dy = -1;
      4: dx = p_cw ? 2 : -2;
      default: ;
    endcase
    tx = 5'(int'(p_x) + dx);
    ty = 6'(int'(p_y) + dy);
    tr = 2'(int'(p_rot) + (p_cw ? 1 : 3));
    px = tx; py = ty; pr = int'(tr);
  endfunction

  task automatic set_plan(input int typ, input bit cw, input int x, input int y, input int rot);
    p_type = 3'(typ); p_cw = cw; p_x = 5'(x); p_y = 6'(y); p_rot = 2'(rot);
    for (int j = 0; j < 5; j++) begin
      p_delay[j] = 1; p_coll[j] = 1'b1; p_early[j] = 1'b0;
    end
    p_abort = -1; p_rst = -1;
  endtask

  task automatic set_pins(input int da, input int rq, input int dn, input int sc,
                          input int nx, input int ny, input int nr);
    pin_done_at = da; pin_req = rq; pin_done = dn; pin_succ = sc;
    pin_nx = nx; pin_ny = ny; pin_nrot = nr;
  endtask

  task automatic idle_one(input bit post_rst, input bit pin);
    @(posedge clk); #1;
    rst_n = 1'b1; abort = 1'b0; rot_req = 1'b0;
    chk_bus.chk_done = 1'b0; chk_bus.chk_collide = 1'b0;
    op_first = 1'b0; pin_en = pin; cyc++;
    e_busy = 1'b0; e_done = 1'b0; e_succ = 1'b0; e_req = 1'b0;
    e_pose_v = post_rst; e_cx = 0; e_cy = 0; e_crot = 0;
    e_nx = m_nx; e_ny = m_ny; e_nrot = m_nrot;
    cmp_en = 1'b1;
  endtask

  // intr: 0 = use p_abort/p_rst as given, 1 = random abort, 2 = random reset
  task automatic run_op(input int intr);
    int s [5];
    int e [5];
    int nused, end_c, stop_c, ab_c, rs_c, st, nt, px, py, pr, gap;
    bit ok, d, c;
    nt = (p_type == 3'd0) ? 5 : 4;
    st = 1; ok = 1'b0; nused = 0;
    for (int j = 0; j < nt; j++) begin
      if (!ok) begin
        s[j]  = st;
        e[j]  = (p_delay[j] != 0) ? p_delay[j] : TIMEOUT - 1;
        nused = j + 1;
        st    = s[j] + 2 + e[j];
        if ((p_delay[j] != 0) && !p_coll[j]) ok = 1'b1;
      end
    end
    end_c = st;
    ab_c = p_abort; rs_c = p_rst;
    if (intr == 1) ab_c = $urandom_range(1, end_c - 1);
    if (intr == 2) rs_c = $urandom_range(1, end_c);
    stop_c = end_c;
    if (ab_c >= 0) stop_c = ab_c;
    else if (rs_c >= 0) stop_c = rs_c;

    for (int t = 0; t <= stop_c; t++) begin
      @(posedge clk); #1;
      cyc = t; op_first = (t == 0); pin_en = 1'b0;
      rst_n = !(t == rs_c);
      abort = (t == ab_c);
      if (t == 0) begin
        rot_req = 1'b1; clockwise = p_cw; piece_type = p_type;
        cur_x = p_x; cur_y = p_y; cur_rot = p_rot;
      end else begin
        rot_req = ($urandom_range(0, 3) == 0);
        clockwise = 1'($urandom_range(0, 1));
        piece_type = 3'($urandom_range(0, 6));
        cur_x = 5'($urandom_range(0, 31));
        cur_y = 6'($urandom_range(0, 63));
        cur_rot = 2'($urandom_range(0, 3));
      end
      d = 1'b0; c = 1'($urandom_range(0, 1));
      for (int j = 0; j < nused; j++) begin
        if ((t == s[j] + 1) && p_early[j]) begin d = 1'b1; c = 1'b0; end
        if ((p_delay[j] != 0) && (t == s[j] + 1 + p_delay[j])) begin d = 1'b1; c = p_coll[j]; end
      end
      chk_bus.chk_done = d; chk_bus.chk_collide = c;

      e_busy = (t >= 1); e_done = (t == end_c); e_succ = ok && (t == end_c);
      e_req = 1'b0; e_pose_v = 1'b0;
      for (int j = 0; j < nused; j++) begin
        if (t == s[j] + 1) e_req = 1'b1;
        if ((t >= s[j]) && (t <= s[j] + 1 + e[j])) begin
          e_pose_v = 1'b1;
          pose(j, px, py, pr);
          e_cx = px; e_cy = py; e_crot = pr;
        end
      end
      if (ok && (t == end_c)) begin
        pose(nused - 1, px, py, pr);
        m_nx = px; m_ny = py; m_nrot = pr;
      end
      e_nx = m_nx; e_ny = m_ny; e_nrot = m_nrot;
      cmp_en = 1'b1;
    end
    if (rs_c >= 0) begin m_nx = 0; m_ny = 0; m_nrot = 0; end
    gap = $urandom_range(1, 3);
    for (int i = 0; i < gap; i++) idle_one((rs_c >= 0) && (i == 0), 1'b0);
  endtask

  task automatic rand_plan();
    int r;
    set_plan($urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
             $urandom_range(0, 63), $urandom_range(0, 3));
    for (int j = 0; j < 5; j++) begin
      r = $urandom_range(0, 9);
      p_delay[j] = (r == 0) ? 0 : (r < 6) ? $urandom_range(1, 3) : $urandom_range(1, TIMEOUT - 1);
      p_coll[j]  = ($urandom_range(0, 2) != 0);
      p_early[j] = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    int r;
    rst_n = 1'b0; rot_req = 1'b0; clockwise = 1'b0; piece_type = 3'd0;
    cur_x = '0; cur_y = '0; cur_rot = '0; abort = 1'b0;
    chk_bus.chk_done = 1'b0; chk_bus.chk_collide = 1'b0;
    cmp_en = 1'b0; op_first = 1'b0; pin_en = 1'b0; cyc = 0;
    m_nx = 0; m_ny = 0; m_nrot = 0;
    set_pins(-1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    idle_one(1'b1, 1'b0);
    idle_one(1'b0, 1'b0);

    // CW from rot 3 wraps to 0, first test clear
    set_plan(3, 1'b1, 4, 0, 3);
    p_coll[0] = 1'b0;
    run_op(0);
    set_pins(4, 1, 1, 1, 4, 0, 0); idle_one(1'b0, 1'b1);

    // T piece CCW, clear on third test; spurious early answers ignored
    set_plan(2, 1'b0, 0, 5, 0);
    p_coll[2] = 1'b0;
    for (int j = 0; j < 5; j++) p_early[j] = 1'b1;
    run_op(0);
    set_pins(10, 3, 1, 1, 1, 5, 3); idle_one(1'b0, 1'b1);

    // I piece CW, all five tests collide (x wraps on the +2 kick)
    set_plan(0, 1'b1, 15, 2, 1);
    run_op(0);
    set_pins(16, 5, 1, 0, 1, 5, 3); idle_one(1'b0, 1'b1);

    // non-I piece, four tests collide
    set_plan(5, 1'b0, -3, -7, 2);
    for (int j = 0; j < 5; j++) p_delay[j] = 2;
    run_op(0);
    set_pins(17, 4, 1, 0, 1, 5, 3); idle_one(1'b0, 1'b1);

    // silent checker: every test times out
    set_plan(1, 1'b1, 2, 2, 2);
    for (int j = 0; j < 5; j++) p_delay[j] = 0;
    run_op(0);
    set_pins(65, 4, 1, 0, 1, 5, 3); idle_one(1'b0, 1'b1);

    // abort coincides with a clear answer
    set_plan(4, 1'b1, 6, 1, 0);
    p_delay[0] = 2; p_coll[0] = 1'b0; p_abort = 4;
    run_op(0);
    set_pins(-1, 1, 0, 0, 1, 5, 3); idle_one(1'b0, 1'b1);

    // reset while waiting
    set_plan(6, 1'b0, 1, 1, 1);
    p_delay[0] = 5; p_coll[0] = 1'b0; p_rst = 3;
    run_op(0);
    set_pins(-1, 1, 0, 0, 0, 0, 0); idle_one(1'b0, 1'b1);

    // normal operation after reset
    set_plan(3, 1'b1, 4, 0, 3);
    p_coll[0] = 1'b0;
    run_op(0);
    set_pins(4, 1, 1, 1, 4, 0, 0); idle_one(1'b0, 1'b1);

    for (int n = 0; n < 80; n++) begin
      rand_plan();
      r = $urandom_range(0, 19);
      run_op((r < 2) ? 1 : (r == 2) ? 2 : 0);
    end

    @(posedge clk); #1;
    cmp_en = 1'b0; pin_en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
`default_nettype wire
